// File: rtl/amidar_input_pkg.sv
// Amidar input controller: scan codes, joystick bit indices and coin FSM states.
package amidar_input_pkg;

   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_CTRL  = 8'h14;
   localparam logic [7:0] SC_F1    = 8'h05;
   localparam logic [7:0] SC_F2    = 8'h06;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_5     = 8'h2E;
   localparam logic [7:0] SC_6     = 8'h36;
   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_F     = 8'h2B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_G     = 8'h34;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_T     = 8'h2C;

   localparam int JOY_RIGHT  = 0;
   localparam int JOY_LEFT   = 1;
   localparam int JOY_DOWN   = 2;
   localparam int JOY_UP     = 3;
   localparam int JOY_FIRE   = 4;
   localparam int JOY_START1 = 5;
   localparam int JOY_START2 = 6;
   localparam int JOY_COIN   = 7;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP,
      WAIT_REL
   } coin_state_t;

   // Returns {left, right, up, down}, remapped for a horizontal screen.
   function automatic logic [3:0] orient(input logic u, input logic d,
                                         input logic l, input logic r,
                                         input logic rot);
      if (rot) return {d, u, l, r};
      return {l, r, u, d};
   endfunction

endpackage

// File: rtl/amidar_input_ctrl_coin.sv
// Coin pulse stretcher: one fixed-length pulse per request, followed by a
// mandatory low gap; a request still held after the gap must be released.
module coin_pulse_fsm
   import amidar_input_pkg::*;
#(
   parameter int COIN_LEN = 2400000,
   parameter int COIN_GAP = 2400000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic req,
   output logic pulse
);

   localparam int MAXC = (COIN_LEN > COIN_GAP) ? COIN_LEN : COIN_GAP;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] LEN_M1 = CW'(COIN_LEN - 1);
   localparam logic [CW-1:0] GAP_M1 = CW'(COIN_GAP - 1);

   coin_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = PULSE;
               cnt_d   = LEN_M1;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_M1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = req ? WAIT_REL : IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         WAIT_REL: begin
            if (!req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output is registered so the pulse starts the edge after the request is taken.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= (state_q == PULSE);
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/amidar_input_ctrl.sv
// Maps MiSTer PS/2 key events and joysticks onto Amidar cabinet inputs,
// including orientation remap and rate-limited coin pulses.
module amidar_input_ctrl
   import amidar_input_pkg::*;
#(
   parameter int COIN_LEN = 2400000,
   parameter int COIN_GAP = 2400000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
   output logic [6:0]  ip_1p,
   output logic [6:0]  ip_2p,
   output logic        ip_coin1,
   output logic        ip_coin2,
   output logic        ip_service
);

   localparam int K_UP = 0,  K_DN = 1,  K_LF = 2,  K_RT = 3;
   localparam int K_SP = 4,  K_CT = 5,  K_F1 = 6,  K_F2 = 7;
   localparam int K_1  = 8,  K_2  = 9,  K_5  = 10, K_6  = 11;
   localparam int K_R  = 12, K_F  = 13, K_D  = 14, K_G  = 15;
   localparam int K_A  = 16, K_T  = 17, NK   = 18;

   logic [NK-1:0] keys_q, keys_d;
   logic          old_tog_q;
   logic [6:0]    ip_1p_q, ip_1p_d, ip_2p_q, ip_2p_d;
   logic          svc_q;
   logic          ev, pr, nx;
   logic [3:0]    d1, d2;
   logic          fire1, fire2, start1, start2, req1, req2;
   logic          unused_joy;

   assign ev = (ps2_key[10] != old_tog_q);
   assign pr = ps2_key[9];
   assign nx = ~ps2_key[8];

   always_comb begin
      keys_d = keys_q;
      if (ev) begin
         case (ps2_key[7:0])
            SC_UP:    keys_d[K_UP] = pr;
            SC_DOWN:  keys_d[K_DN] = pr;
            SC_LEFT:  keys_d[K_LF] = pr;
            SC_RIGHT: keys_d[K_RT] = pr;
            SC_SPACE: if (nx) keys_d[K_SP] = pr;
            SC_CTRL:  if (nx) keys_d[K_CT] = pr;
            SC_F1:    if (nx) keys_d[K_F1] = pr;
            SC_F2:    if (nx) keys_d[K_F2] = pr;
            SC_1:     if (nx) keys_d[K_1]  = pr;
            SC_2:     if (nx) keys_d[K_2]  = pr;
            SC_5:     if (nx) keys_d[K_5]  = pr;
            SC_6:     if (nx) keys_d[K_6]  = pr;
            SC_R:     if (nx) keys_d[K_R]  = pr;
            SC_F:     if (nx) keys_d[K_F]  = pr;
            SC_D:     if (nx) keys_d[K_D]  = pr;
            SC_G:     if (nx) keys_d[K_G]  = pr;
            SC_A:     if (nx) keys_d[K_A]  = pr;
            SC_T:     if (nx) keys_d[K_T]  = pr;
            default:  ;
         endcase
      end
   end

   assign d1 = orient(keys_q[K_UP] | joystick_0[JOY_UP],
                      keys_q[K_DN] | joystick_0[JOY_DOWN],
                      keys_q[K_LF] | joystick_0[JOY_LEFT],
                      keys_q[K_RT] | joystick_0[JOY_RIGHT], rotate);
   assign d2 = orient(keys_q[K_R] | joystick_1[JOY_UP],
                      keys_q[K_F] | joystick_1[JOY_DOWN],
                      keys_q[K_D] | joystick_1[JOY_LEFT],
                      keys_q[K_G] | joystick_1[JOY_RIGHT], rotate);

   assign fire1  = keys_q[K_SP] | keys_q[K_CT] | joystick_0[JOY_FIRE];
   assign fire2  = keys_q[K_A] | joystick_1[JOY_FIRE];
   assign start1 = keys_q[K_F1] | keys_q[K_1] | joystick_0[JOY_START1];
   assign start2 = keys_q[K_F2] | keys_q[K_2] | joystick_1[JOY_START1];
   assign req1   = keys_q[K_5] | keys_q[K_F1] | keys_q[K_F2]
                 | joystick_0[JOY_COIN];
   assign req2   = keys_q[K_6] | joystick_1[JOY_COIN];

   assign ip_1p_d = ~{start1, fire1, fire1, d1};
   assign ip_2p_d = ~{start2, fire2, fire2, d2};

   assign unused_joy = ^{joystick_0[15:8], joystick_0[JOY_START2],
                         joystick_1[15:8], joystick_1[JOY_START2]};

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         keys_q    <= '0;
         old_tog_q <= 1'b0;
         ip_1p_q   <= 7'h7F;
         ip_2p_q   <= 7'h7F;
         svc_q     <= 1'b1;
      end else begin
         keys_q    <= keys_d;
         old_tog_q <= ps2_key[10];
         ip_1p_q   <= ip_1p_d;
         ip_2p_q   <= ip_2p_d;
         svc_q     <= ~keys_q[K_T];
      end
   end

   coin_pulse_fsm #(.COIN_LEN(COIN_LEN), .COIN_GAP(COIN_GAP)) u_coin1 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req     (req1),
      .pulse   (ip_coin1)
   );

   coin_pulse_fsm #(.COIN_LEN(COIN_LEN), .COIN_GAP(COIN_GAP)) u_coin2 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req     (req2),
      .pulse   (ip_coin2)
   );

   assign ip_1p      = ip_1p_q;
   assign ip_2p      = ip_2p_q;
   assign ip_service = svc_q;

endmodule

// File: tb/tb_amidar_input_ctrl.sv
// Directed bench for amidar_input_ctrl with COIN_LEN=4, COIN_GAP=3.
module tb_amidar_input_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] ps2_key = '0;
   logic [15:0] joystick_0 = '0;
   logic [15:0] joystick_1 = '0;
   logic        rotate = 1'b0;
   logic [6:0]  ip_1p, ip_2p;
   logic        ip_coin1, ip_coin2, ip_service;

   int tests_run = 0;
   int tests_failed = 0;

   amidar_input_ctrl #(.COIN_LEN(4), .COIN_GAP(3)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .rotate     (rotate),
      .ip_1p      (ip_1p),
      .ip_2p      (ip_2p),
      .ip_coin1   (ip_coin1),
      .ip_coin2   (ip_coin2),
      .ip_service (ip_service)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic send(input logic ext, input logic pressed,
                       input logic [7:0] code);
      ps2_key = {~ps2_key[10], pressed, ext, code};
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests_run++;
      if (ip_1p !== 7'h7F) begin
         tests_failed++;
         $display("FAIL reset_ip_1p got %h want 7f", ip_1p);
      end
      tests_run++;
      if (ip_2p !== 7'h7F) begin
         tests_failed++;
         $display("FAIL reset_ip_2p got %h want 7f", ip_2p);
      end
      tests_run++;
      if ({ip_coin1, ip_coin2, ip_service} !== 3'b001) begin
         tests_failed++;
         $display("FAIL reset_coin_svc got %b want 001",
                  {ip_coin1, ip_coin2, ip_service});
      end
   endtask

   task automatic test_arrow;
      for (int e = 0; e < 2; e++) begin
         send(e[0], 1'b1, 8'h75);
         step();
         tests_run++;
         if (ip_1p !== 7'h7F) begin
            tests_failed++;
            $display("FAIL arrow_latency ext=%0d got %h want 7f", e, ip_1p);
         end
         step();
         tests_run++;
         if (ip_1p !== 7'h7D) begin
            tests_failed++;
            $display("FAIL arrow_up ext=%0d got %h want 7d", e, ip_1p);
         end
         send(e[0], 1'b0, 8'h75);
         step(2);
         tests_run++;
         if (ip_1p !== 7'h7F) begin
            tests_failed++;
            $display("FAIL arrow_release ext=%0d got %h want 7f", e, ip_1p);
         end
      end
   endtask

   task automatic test_rotate;
      rotate = 1'b1;
      joystick_0 = 16'h0002;
      step();
      tests_run++;
      if (ip_1p !== 7'h7D) begin
         tests_failed++;
         $display("FAIL rotate_left_to_up got %h want 7d", ip_1p);
      end
      rotate = 1'b0;
      step();
      tests_run++;
      if (ip_1p !== 7'h77) begin
         tests_failed++;
         $display("FAIL norotate_left got %h want 77", ip_1p);
      end
      joystick_0 = '0;
      step();
      tests_run++;
      if (ip_1p !== 7'h7F) begin
         tests_failed++;
         $display("FAIL joy_release got %h want 7f", ip_1p);
      end
   endtask

   task automatic test_back_to_back;
      send(1'b0, 1'b1, 8'h2D);
      step();
      send(1'b0, 1'b1, 8'h1C);
      step(2);
      tests_run++;
      if (ip_2p !== 7'h4D) begin
         tests_failed++;
         $display("FAIL p2_up_fire got %h want 4d", ip_2p);
      end
      send(1'b0, 1'b0, 8'h2D);
      step();
      send(1'b0, 1'b0, 8'h1C);
      step(2);
      tests_run++;
      if (ip_2p !== 7'h7F) begin
         tests_failed++;
         $display("FAIL p2_release got %h want 7f", ip_2p);
      end
      send(1'b0, 1'b1, 8'h2C);
      step(2);
      tests_run++;
      if (ip_service !== 1'b0) begin
         tests_failed++;
         $display("FAIL service_press got %b want 0", ip_service);
      end
      send(1'b0, 1'b0, 8'h2C);
      step(2);
      tests_run++;
      if (ip_service !== 1'b1) begin
         tests_failed++;
         $display("FAIL service_release got %b want 1", ip_service);
      end
   endtask

   task automatic test_coin_hold;
      int first, highs, rises, lat;
      logic prev;
      first = -1; highs = 0; rises = 0; prev = 1'b0;
      send(1'b0, 1'b1, 8'h2E);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (ip_coin1) begin
            highs++;
            if (first < 0) first = i;
         end
         if (ip_coin1 && !prev) rises++;
         prev = ip_coin1;
      end
      tests_run++;
      if (first !== 3) begin
         tests_failed++;
         $display("FAIL coin_hold_start got %0d want 3", first);
      end
      tests_run++;
      if (highs !== 4 || rises !== 1) begin
         tests_failed++;
         $display("FAIL coin_hold_len got highs=%0d rises=%0d want 4/1",
                  highs, rises);
      end
      send(1'b0, 1'b0, 8'h2E);
      step(3);
      send(1'b0, 1'b1, 8'h2E);
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         step();
         if (ip_coin1) lat = i;
      end
      tests_run++;
      if (lat !== 3) begin
         tests_failed++;
         $display("FAIL coin_repress_latency got %0d want 3", lat);
      end
      send(1'b0, 1'b0, 8'h2E);
      step(12);
   endtask

   task automatic test_coin_reset;
      int lat, highs;
      joystick_0 = 16'h0080;
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         step();
         if (ip_coin1) lat = i;
      end
      tests_run++;
      if (lat !== 2) begin
         tests_failed++;
         $display("FAIL joycoin_latency got %0d want 2", lat);
      end
      step();
      reset = 1'b1;
      step();
      tests_run++;
      if (ip_coin1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL coin_midpulse_reset got %b want 0", ip_coin1);
      end
      reset = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         step();
         if (ip_coin1) lat = i;
      end
      highs = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ip_coin1) highs++;
      end
      tests_run++;
      if (lat !== 2 || highs !== 4) begin
         tests_failed++;
         $display("FAIL coin_after_reset got lat=%0d highs=%0d want 2/4",
                  lat, highs);
      end
      joystick_0 = '0;
      step(3);
   endtask

   task automatic test_coin2;
      int highs, first;
      highs = 0; first = -1;
      joystick_1 = 16'h0080;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (ip_coin2) begin
            highs++;
            if (first < 0) first = i;
         end
         if (ip_coin1) highs += 100;
      end
      tests_run++;
      if (first !== 2 || highs !== 4) begin
         tests_failed++;
         $display("FAIL coin2_pulse got first=%0d highs=%0d want 2/4",
                  first, highs);
      end
      joystick_1 = '0;
      step(3);
   endtask

   task automatic test_ignored;
      int highs;
      highs = 0;
      ps2_key = {ps2_key[10], 1'b1, 1'b0, 8'h2E};
      for (int i = 0; i < 8; i++) begin
         step();
         if (ip_coin1) highs++;
      end
      tests_run++;
      if (highs !== 0) begin
         tests_failed++;
         $display("FAIL no_toggle_coin got %0d high cycles want 0", highs);
      end
      send(1'b0, 1'b1, 8'h0F);
      step(3);
      tests_run++;
      if ({ip_1p, ip_2p, ip_coin1, ip_coin2, ip_service}
          !== {7'h7F, 7'h7F, 3'b001}) begin
         tests_failed++;
         $display("FAIL unmapped_code got %h %h %b%b%b want 7f 7f 001",
                  ip_1p, ip_2p, ip_coin1, ip_coin2, ip_service);
      end
      send(1'b1, 1'b1, 8'h29);
      step(2);
      tests_run++;
      if (ip_1p !== 7'h7F) begin
         tests_failed++;
         $display("FAIL ext_space_ignored got %h want 7f", ip_1p);
      end
   endtask

   initial begin
      test_reset();
      test_arrow();
      test_rotate();
      test_back_to_back();
      test_coin_hold();
      test_coin_reset();
      test_coin2();
      test_ignored();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
